dbf_line_seq: RTL and testbench
===============================

Name: dbf_line_seq

Overview:
- Per-scanline sequencer for the DBF channel array.
- Generates the shared tx_en, start, dbf_lut_addr and dbf_lut_we that drive every dbf_chNN instance.
- Order per line: transmit window, dead time, receive window. During receive, steps through dynamic-focus zones by reading the coarse/fine delay LUTs once per zone.
- Sits between the system control (line trigger/abort) and the channel bank.

Parameters:
ADDR_WD, 9, width of dbf_lut_addr; must satisfy 2^ADDR_WD >= NUM_LINES*NUM_ZONES
NUM_LINES, 128, scanlines per frame
TX_CYCLES, 8, clocks tx_en is held high
DEAD_CYCLES, 16, clocks between tx_en fall and start rise
RX_SAMPLES, 256, clocks start is held high per line
ZONE_LEN, 64, receive samples per focal zone; NUM_ZONES = RX_SAMPLES/ZONE_LEN (integer, >=1)
CNT_WD, 16, width of internal cycle counters

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous, active-high reset (1 = reset asserted)
line_go  in  1  single-cycle request to fire the next scanline; honoured only in IDLE
abort  in  1  synchronous abort; highest priority after reset
tx_en  out  1  transmit window to channels (channels treat ~tx_en as sample valid)
start  out  1  receive window to channels
dbf_lut_addr  out  ADDR_WD  delay LUT address = line_cnt*NUM_ZONES + zone_idx
dbf_lut_we  out  1  one-cycle LUT access strobe at each zone boundary
busy  out  1  high in any state except IDLE
line_done  out  1  one-cycle pulse when a line completes normally
frame_done  out  1  one-cycle pulse coincident with line_done of line NUM_LINES-1
line_cnt  out  log2(NUM_LINES)  index of the current/next line

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. All outputs 0: tx_en, start, dbf_lut_addr, dbf_lut_we, busy, line_done, frame_done, line_cnt. Internal counters 0.
- All outputs are registered. The state transition and its outputs take effect on the same clock edge.
- IDLE: line_go=1 -> TX on the next edge; otherwise stay in IDLE.
- TX: tx_en=1 for exactly TX_CYCLES clocks, then DEAD.
- DEAD: tx_en=0, start=0 for exactly DEAD_CYCLES clocks, then RX.
- RX: start=1 for exactly RX_SAMPLES clocks.
  - zone_idx starts at 0 and increments after every ZONE_LEN samples.
  - dbf_lut_we=1 on the first RX cycle and on every cycle where sample_cnt mod ZONE_LEN == 0; otherwise 0. That gives NUM_ZONES strobes per line.
  - dbf_lut_addr is updated in the same cycle as its strobe and held between strobes.
  - Exit to DONE after the last sample.
- DONE (1 cycle):
  - line_done=1 and busy=1.
  - line_cnt increments; it wraps from NUM_LINES-1 to 0, and frame_done=1 in that case.
  - Return to IDLE. dbf_lut_addr is held, not cleared.
- Latency: line_go to tx_en rise is 1 clock. tx_en fall to start rise is DEAD_CYCLES clocks. Total busy time is TX_CYCLES+DEAD_CYCLES+RX_SAMPLES+1 clocks.
- line_go outside IDLE is ignored and not queued. line_go in the DONE cycle is also ignored.
- abort=1 in any non-IDLE state:
  - Next edge: IDLE, with tx_en, start, dbf_lut_we and busy cleared.
  - No line_done and no frame_done. line_cnt unchanged, so the same line is re-fired by the next line_go.
- abort and line_go together in IDLE: abort wins and the FSM stays in IDLE.
- Reset mid-line: immediate return to reset values, including line_cnt=0.
- tx_en and start are never high in the same cycle.

Test Plan:
1. Reset, then line_go pulse with defaults:
   - tx_en high for cycles 1-8.
   - start high for cycles 25-280.
   - line_done at cycle 281; busy low at cycle 282.
2. Zone strobes on line_cnt=3:
   - dbf_lut_we pulses exactly at RX samples 0, 64, 128 and 192.
   - dbf_lut_addr = 12, 13, 14, 15 at those pulses.
3. 128 back-to-back lines:
   - line_cnt wraps 127 -> 0.
   - frame_done high exactly once, coincident with the 128th line_done.
   - Addresses of line 127 are 508-511.
4. abort at RX sample 100:
   - start drops the next cycle; no line_done; line_cnt unchanged.
   - The next line_go replays the same addresses from zone 0.
5. line_go pulsed during TX, DEAD, RX and DONE: no extra line and no timing change. abort+line_go together in IDLE: FSM stays idle.
6. rst_n asserted asynchronously mid-DEAD: all outputs 0 immediately and line_cnt=0. After release, line_go starts line 0 normally.

Source files
------------

// File: rtl/dbf_line_seq.sv
// Per-scanline sequencer for the DBF channel array: transmit window, dead time,
// then a receive window that steps the shared delay-LUT address once per focal zone.
module dbf_line_seq #(
    parameter int ADDR_WD     = 9,
    parameter int NUM_LINES   = 128,
    parameter int TX_CYCLES   = 8,
    parameter int DEAD_CYCLES = 16,
    parameter int RX_SAMPLES  = 256,
    parameter int ZONE_LEN    = 64,
    parameter int CNT_WD      = 16,
    localparam int LINE_WD    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               line_go,
    input  logic               abort,
    output logic               tx_en,
    output logic               start,
    output logic [ADDR_WD-1:0] dbf_lut_addr,
    output logic               dbf_lut_we,
    output logic               busy,
    output logic               line_done,
    output logic               frame_done,
    output logic [LINE_WD-1:0] line_cnt,
    output logic [2:0]         state_dbg
);

    localparam int NUM_ZONES = RX_SAMPLES / ZONE_LEN;
    localparam int ZONE_WD   = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;

    localparam logic [CNT_WD-1:0]  TX_LAST   = CNT_WD'(TX_CYCLES - 1);
    localparam logic [CNT_WD-1:0]  DEAD_LAST = CNT_WD'(DEAD_CYCLES - 1);
    localparam logic [CNT_WD-1:0]  RX_LAST   = CNT_WD'(RX_SAMPLES - 1);
    localparam logic [CNT_WD-1:0]  ZONE_LAST = CNT_WD'(ZONE_LEN - 1);
    localparam logic [LINE_WD-1:0] LINE_LAST = LINE_WD'(NUM_LINES - 1);

    // Control handshake: line_go and abort are single-cycle requests with no
    // ready; line_go is accepted only when the sequencer is IDLE and abort is
    // low, otherwise it is dropped. abort always wins over line_go.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TX   = 3'd1,
        S_DEAD = 3'd2,
        S_RX   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_WD-1:0]  cnt_q, cnt_d;
    logic [CNT_WD-1:0]  zs_q, zs_d;
    logic [ZONE_WD-1:0] zone_q, zone_d;
    logic [ZONE_WD-1:0] zone_nxt;
    logic [LINE_WD-1:0] line_q, line_d;
    logic [ADDR_WD-1:0] addr_q, addr_d;
    logic [ADDR_WD-1:0] line_base;
    logic               tx_q, tx_d;
    logic               start_q, start_d;
    logic               we_q, we_d;
    logic               busy_q, busy_d;
    logic               ldone_q, ldone_d;
    logic               fdone_q, fdone_d;

    assign zone_nxt  = zone_q + ZONE_WD'(1);
    assign line_base = ADDR_WD'(line_q) * ADDR_WD'(NUM_ZONES);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            zs_q    <= '0;
            zone_q  <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            tx_q    <= 1'b0;
            start_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            ldone_q <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zs_q    <= zs_d;
            zone_q  <= zone_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            tx_q    <= tx_d;
            start_q <= start_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            ldone_q <= ldone_d;
            fdone_q <= fdone_d;
        end
    end

    // Outputs are computed for the state being entered so they register on
    // the same edge as the transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zs_d    = zs_q;
        zone_d  = zone_q;
        line_d  = line_q;
        addr_d  = addr_q;
        tx_d    = 1'b0;
        start_d = 1'b0;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        ldone_d = 1'b0;
        fdone_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (line_go && !abort) begin
                    state_d = S_TX;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_TX: begin
                busy_d = 1'b1;
                if (cnt_q == TX_LAST) begin
                    state_d = S_DEAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WD'(1);
                    tx_d  = 1'b1;
                end
            end
            S_DEAD: begin
                busy_d = 1'b1;
                if (cnt_q == DEAD_LAST) begin
                    state_d = S_RX;
                    cnt_d   = '0;
                    zs_d    = '0;
                    zone_d  = '0;
                    start_d = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = line_base;
                end else begin
                    cnt_d = cnt_q + CNT_WD'(1);
                end
            end
            S_RX: begin
                busy_d = 1'b1;
                if (cnt_q == RX_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    ldone_d = 1'b1;
                    if (line_q == LINE_LAST) begin
                        line_d  = '0;
                        fdone_d = 1'b1;
                    end else begin
                        line_d = line_q + LINE_WD'(1);
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_WD'(1);
                    start_d = 1'b1;
                    if (zs_q == ZONE_LAST) begin
                        zs_d   = '0;
                        zone_d = zone_nxt;
                        we_d   = 1'b1;
                        addr_d = line_base + ADDR_WD'(zone_nxt);
                    end else begin
                        zs_d = zs_q + CNT_WD'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort drops the line without completing it; line_q and addr_q are
        // kept so the next line_go replays the same line from zone 0.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            zs_d    = '0;
            zone_d  = '0;
            line_d  = line_q;
            tx_d    = 1'b0;
            start_d = 1'b0;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            ldone_d = 1'b0;
            fdone_d = 1'b0;
        end
    end

    assign tx_en        = tx_q;
    assign start        = start_q;
    assign dbf_lut_addr = addr_q;
    assign dbf_lut_we   = we_q;
    assign busy         = busy_q;
    assign line_done    = ldone_q;
    assign frame_done   = fdone_q;
    assign line_cnt     = line_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_dbf_line_seq.sv
// Bench for dbf_line_seq: per-feature tasks with inline checks, and a LUT
// address scoreboard drained by a monitor on every dbf_lut_we strobe.
module tb_dbf_line_seq;

    localparam int ADDR_WD = 9;
    localparam int LINE_WD = 7;

    logic               clk;
    logic               rst;
    logic               line_go;
    logic               abort;
    logic               tx_en;
    logic               start;
    logic [ADDR_WD-1:0] dbf_lut_addr;
    logic               dbf_lut_we;
    logic               busy;
    logic               line_done;
    logic               frame_done;
    logic [LINE_WD-1:0] line_cnt;
    logic [2:0]         state_dbg;

    int n_vec;
    int n_err;

    logic [ADDR_WD-1:0] exp_q[$];

    // Results of the most recent fire() call
    int m_tx_first, m_tx_last, m_st_first, m_st_last;
    int m_done_n, m_done_cyc, m_frame_n, m_frame_bad, m_busy_low, m_we_n;
    int m_we_pos[8];
    int m_we_addr[8];

    dbf_line_seq #(
        .ADDR_WD(9), .NUM_LINES(128), .TX_CYCLES(8), .DEAD_CYCLES(16),
        .RX_SAMPLES(256), .ZONE_LEN(64), .CNT_WD(16)
    ) dut (
        .clk(clk), .rst_n(rst), .line_go(line_go), .abort(abort),
        .tx_en(tx_en), .start(start), .dbf_lut_addr(dbf_lut_addr),
        .dbf_lut_we(dbf_lut_we), .busy(busy), .line_done(line_done),
        .frame_done(frame_done), .line_cnt(line_cnt), .state_dbg(state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (dbf_lut_we) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL lut_we_unexpected: addr got %0d, required no strobe", dbf_lut_addr);
                end else begin
                    logic [ADDR_WD-1:0] e;
                    e = exp_q.pop_front();
                    if (dbf_lut_addr !== e) begin
                        n_err++;
                        $display("FAIL lut_addr: got %0d required %0d", dbf_lut_addr, e);
                    end
                end
            end
            if (tx_en && start) begin
                n_vec++;
                n_err++;
                $display("FAIL tx_start_overlap: got tx_en=1 start=1 required not both");
            end
        end
    end

    // Driver tasks
    task automatic push_line(input int ln, input int nz);
        for (int z = 0; z < nz; z++) exp_q.push_back(ADDR_WD'(ln * 4 + z));
    endtask

    task automatic fire(input int abort_at, input bit extra_go);
        int c;
        int st_idx;
        bit fin;
        m_tx_first = -1; m_tx_last = -1; m_st_first = -1; m_st_last = -1;
        m_done_n = 0; m_done_cyc = -1; m_frame_n = 0; m_frame_bad = 0;
        m_busy_low = -1; m_we_n = 0;
        for (int i = 0; i < 8; i++) begin m_we_pos[i] = -1; m_we_addr[i] = -1; end
        @(negedge clk);
        line_go = 1'b1;
        @(negedge clk);
        line_go = 1'b0;
        c = 1;
        st_idx = 0;
        fin = 1'b0;
        while (!fin && c < 400) begin
            if (tx_en) begin
                if (m_tx_first < 0) m_tx_first = c;
                m_tx_last = c;
            end
            if (start) begin
                if (m_st_first < 0) m_st_first = c;
                m_st_last = c;
            end
            if (dbf_lut_we) begin
                if (m_we_n < 8) begin
                    m_we_pos[m_we_n]  = st_idx;
                    m_we_addr[m_we_n] = int'(dbf_lut_addr);
                end
                m_we_n++;
            end
            if (line_done) begin m_done_n++; m_done_cyc = c; end
            if (frame_done) begin
                m_frame_n++;
                if (!line_done) m_frame_bad++;
            end
            line_go = extra_go && (c == 3 || c == 15 || c == 100 || c == 281);
            abort   = (abort_at >= 0) && start && (st_idx == abort_at);
            if (start) st_idx++;
            if (!busy) begin
                m_busy_low = c;
                fin = 1'b1;
            end else begin
                @(negedge clk);
                c++;
            end
        end
        line_go = 1'b0;
        abort   = 1'b0;
        n_vec++;
        if (!fin) begin
            n_err++;
            $display("FAIL line_timeout: busy still high after %0d cycles, required low", c);
        end
    endtask

    // Tests
    task automatic test_reset();
        rst = 1'b1; line_go = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        n_vec += 9;
        if (tx_en !== 1'b0)        begin n_err++; $display("FAIL rst_tx_en: got %b required 0", tx_en); end
        if (start !== 1'b0)        begin n_err++; $display("FAIL rst_start: got %b required 0", start); end
        if (dbf_lut_addr !== '0)   begin n_err++; $display("FAIL rst_addr: got %0d required 0", dbf_lut_addr); end
        if (dbf_lut_we !== 1'b0)   begin n_err++; $display("FAIL rst_we: got %b required 0", dbf_lut_we); end
        if (busy !== 1'b0)         begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (line_done !== 1'b0)    begin n_err++; $display("FAIL rst_line_done: got %b required 0", line_done); end
        if (frame_done !== 1'b0)   begin n_err++; $display("FAIL rst_frame_done: got %b required 0", frame_done); end
        if (line_cnt !== '0)       begin n_err++; $display("FAIL rst_line_cnt: got %0d required 0", line_cnt); end
        if (state_dbg !== 3'd0)    begin n_err++; $display("FAIL rst_state: got %0d required 0", state_dbg); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_line();
        push_line(0, 4);
        fire(-1, 1'b0);
        n_vec += 9;
        if (m_tx_first != 1)   begin n_err++; $display("FAIL tx_rise: got %0d required 1", m_tx_first); end
        if (m_tx_last != 8)    begin n_err++; $display("FAIL tx_fall: got %0d required 8", m_tx_last); end
        if (m_st_first != 25)  begin n_err++; $display("FAIL start_rise: got %0d required 25", m_st_first); end
        if (m_st_last != 280)  begin n_err++; $display("FAIL start_fall: got %0d required 280", m_st_last); end
        if (m_done_cyc != 281) begin n_err++; $display("FAIL line_done_cyc: got %0d required 281", m_done_cyc); end
        if (m_done_n != 1)     begin n_err++; $display("FAIL line_done_n: got %0d required 1", m_done_n); end
        if (m_frame_n != 0)    begin n_err++; $display("FAIL frame_done_n: got %0d required 0", m_frame_n); end
        if (m_busy_low != 282) begin n_err++; $display("FAIL busy_fall: got %0d required 282", m_busy_low); end
        if (line_cnt !== 7'd1) begin n_err++; $display("FAIL line_cnt_after0: got %0d required 1", line_cnt); end
    endtask

    task automatic test_zones();
        for (int ln = 1; ln <= 3; ln++) begin
            push_line(ln, 4);
            fire(-1, 1'b0);
        end
        n_vec++;
        if (m_we_n != 4) begin n_err++; $display("FAIL zone_we_count: got %0d required 4", m_we_n); end
        for (int z = 0; z < 4; z++) begin
            n_vec += 2;
            if (m_we_pos[z] != z * 64) begin
                n_err++; $display("FAIL zone_we_pos%0d: got %0d required %0d", z, m_we_pos[z], z * 64);
            end
            if (m_we_addr[z] != 12 + z) begin
                n_err++; $display("FAIL zone_addr%0d: got %0d required %0d", z, m_we_addr[z], 12 + z);
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL zone_sb_left: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_abort();
        push_line(4, 2);
        fire(100, 1'b0);
        n_vec += 5;
        if (m_st_last != 125)  begin n_err++; $display("FAIL abort_start_last: got %0d required 125", m_st_last); end
        if (m_busy_low != 126) begin n_err++; $display("FAIL abort_busy_fall: got %0d required 126", m_busy_low); end
        if (m_done_n != 0)     begin n_err++; $display("FAIL abort_line_done: got %0d required 0", m_done_n); end
        if (m_we_n != 2)       begin n_err++; $display("FAIL abort_we_count: got %0d required 2", m_we_n); end
        if (line_cnt !== 7'd4) begin n_err++; $display("FAIL abort_line_cnt: got %0d required 4", line_cnt); end
        push_line(4, 4);
        fire(-1, 1'b0);
        n_vec += 4;
        if (m_we_addr[0] != 16) begin n_err++; $display("FAIL replay_addr0: got %0d required 16", m_we_addr[0]); end
        if (m_we_pos[0] != 0)   begin n_err++; $display("FAIL replay_pos0: got %0d required 0", m_we_pos[0]); end
        if (m_done_n != 1)      begin n_err++; $display("FAIL replay_done: got %0d required 1", m_done_n); end
        if (line_cnt !== 7'd5)  begin n_err++; $display("FAIL replay_line_cnt: got %0d required 5", line_cnt); end
    endtask

    task automatic test_ignore_go();
        push_line(5, 4);
        fire(-1, 1'b1);
        n_vec += 5;
        if (m_tx_last != 8)    begin n_err++; $display("FAIL ign_tx_fall: got %0d required 8", m_tx_last); end
        if (m_st_first != 25)  begin n_err++; $display("FAIL ign_start_rise: got %0d required 25", m_st_first); end
        if (m_done_cyc != 281) begin n_err++; $display("FAIL ign_done_cyc: got %0d required 281", m_done_cyc); end
        if (m_done_n != 1)     begin n_err++; $display("FAIL ign_done_n: got %0d required 1", m_done_n); end
        if (m_busy_low != 282) begin n_err++; $display("FAIL ign_busy_fall: got %0d required 282", m_busy_low); end
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL ign_extra_line: busy got %b required 0", busy); end
        line_go = 1'b1; abort = 1'b1;
        @(negedge clk);
        line_go = 1'b0; abort = 1'b0;
        n_vec += 4;
        if (busy !== 1'b0)      begin n_err++; $display("FAIL go_abort_busy: got %b required 0", busy); end
        if (tx_en !== 1'b0)     begin n_err++; $display("FAIL go_abort_tx: got %b required 0", tx_en); end
        if (state_dbg !== 3'd0) begin n_err++; $display("FAIL go_abort_state: got %0d required 0", state_dbg); end
        if (line_cnt !== 7'd6)  begin n_err++; $display("FAIL go_abort_line_cnt: got %0d required 6", line_cnt); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        line_go = 1'b1;
        @(negedge clk);
        line_go = 1'b0;
        repeat (14) @(negedge clk);
        n_vec++;
        if (state_dbg !== 3'd2) begin n_err++; $display("FAIL ar_in_dead: state got %0d required 2", state_dbg); end
        #2 rst = 1'b1;
        #1;
        n_vec += 6;
        if (busy !== 1'b0)        begin n_err++; $display("FAIL ar_busy: got %b required 0", busy); end
        if (tx_en !== 1'b0)       begin n_err++; $display("FAIL ar_tx: got %b required 0", tx_en); end
        if (start !== 1'b0)       begin n_err++; $display("FAIL ar_start: got %b required 0", start); end
        if (dbf_lut_addr !== '0)  begin n_err++; $display("FAIL ar_addr: got %0d required 0", dbf_lut_addr); end
        if (line_cnt !== '0)      begin n_err++; $display("FAIL ar_line_cnt: got %0d required 0", line_cnt); end
        if (state_dbg !== 3'd0)   begin n_err++; $display("FAIL ar_state: got %0d required 0", state_dbg); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_line(0, 4);
        fire(-1, 1'b0);
        n_vec += 4;
        if (m_we_addr[0] != 0) begin n_err++; $display("FAIL ar_relaunch_addr: got %0d required 0", m_we_addr[0]); end
        if (m_st_first != 25)  begin n_err++; $display("FAIL ar_relaunch_start: got %0d required 25", m_st_first); end
        if (m_done_n != 1)     begin n_err++; $display("FAIL ar_relaunch_done: got %0d required 1", m_done_n); end
        if (line_cnt !== 7'd1) begin n_err++; $display("FAIL ar_relaunch_line_cnt: got %0d required 1", line_cnt); end
    endtask

    task automatic test_back_to_back();
        int frames;
        int frame_line;
        int bad;
        frames = 0; frame_line = -1; bad = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int ln = 0; ln < 128; ln++) begin
            push_line(ln, 4);
            fire(-1, 1'b0);
            n_vec++;
            if (m_done_n != 1) begin n_err++; $display("FAIL b2b_done_line%0d: got %0d required 1", ln, m_done_n); end
            if (m_frame_n != 0) begin frames += m_frame_n; frame_line = ln; end
            bad += m_frame_bad;
            if (ln == 127) begin
                for (int z = 0; z < 4; z++) begin
                    n_vec++;
                    if (m_we_addr[z] != 508 + z) begin
                        n_err++; $display("FAIL b2b_addr127_%0d: got %0d required %0d", z, m_we_addr[z], 508 + z);
                    end
                end
            end
        end
        n_vec += 5;
        if (frames != 1)        begin n_err++; $display("FAIL b2b_frame_count: got %0d required 1", frames); end
        if (frame_line != 127)  begin n_err++; $display("FAIL b2b_frame_line: got %0d required 127", frame_line); end
        if (bad != 0)           begin n_err++; $display("FAIL b2b_frame_coincide: got %0d stray required 0", bad); end
        if (line_cnt !== '0)    begin n_err++; $display("FAIL b2b_wrap: got %0d required 0", line_cnt); end
        if (exp_q.size() != 0)  begin n_err++; $display("FAIL b2b_sb_left: got %0d required 0", exp_q.size()); end
    endtask

    // Sequence and final report
    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        line_go = 1'b0;
        abort = 1'b0;
        test_reset();
        test_single_line();
        test_zones();
        test_abort();
        test_ignore_go();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
